// File: rtl/mem_bus_arbiter.sv
// Shares one multi-cycle main-memory port between the I-fetch and D-access paths.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise D has fixed priority.
module mem_bus_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_D,
    GRANT_I,
    RELEASE
  } state_t;

  state_t     state;
  logic       served_d;
  logic [1:0] cnt;
  logic       d_req;
  logic       i_req;
  logic       pick_d;
  logic       done;

  assign d_req = D_READ | D_WRITE;
  assign i_req = I_READ;

`ifdef MEM_ARB_RR_EN
  // on contention, hand the port to whoever was not served last
  assign pick_d = d_req & (~i_req | ~served_d);
`else
  assign pick_d = d_req;
`endif

  // memory busy may not have risen yet in the grant cycle
  assign done = (cnt != 2'd0) & ~MEM_BUSYWAIT;

  assign I_BUSYWAIT = ~RESET & i_req &
                      ~((state == RELEASE) & ~served_d);
  assign D_BUSYWAIT = ~RESET & d_req &
                      ~((state == RELEASE) & served_d);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= IDLE;
      served_d      <= 1'b0;
      cnt           <= 2'd0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
      I_READDATA    <= '0;
      D_READDATA    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= 2'd0;
          if (pick_d) begin
            state         <= GRANT_D;
            served_d      <= 1'b1;
            MEM_WRITE     <= D_WRITE;
            MEM_READ      <= D_READ & ~D_WRITE;
            MEM_ADDRESS   <= D_ADDRESS;
            MEM_WRITEDATA <= D_WRITEDATA;
          end else if (i_req) begin
            state       <= GRANT_I;
            served_d    <= 1'b0;
            MEM_WRITE   <= 1'b0;
            MEM_READ    <= 1'b1;
            MEM_ADDRESS <= I_ADDRESS;
          end
        end
        GRANT_D, GRANT_I: begin
          if (done) begin
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
            state     <= RELEASE;
            if (MEM_READ) begin
              if (state == GRANT_D && D_READ)
                D_READDATA <= MEM_READDATA;
              if (state == GRANT_I && I_READ)
                I_READDATA <= MEM_READDATA;
            end
          end else if (cnt != 2'd3) begin
            cnt <= cnt + 2'd1;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter with a transaction-level reference model
// and a small latency-programmable main-memory model.
module tb_mem_bus_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int DS = 1;
  localparam int IS = 2;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          I_READ = 1'b0;
  logic [AW-1:0] I_ADDRESS = '0;
  logic [DW-1:0] I_READDATA;
  logic          I_BUSYWAIT;
  logic          D_READ = 1'b0;
  logic          D_WRITE = 1'b0;
  logic [AW-1:0] D_ADDRESS = '0;
  logic [DW-1:0] D_WRITEDATA = '0;
  logic [DW-1:0] D_READDATA;
  logic          D_BUSYWAIT;
  logic          MEM_READ;
  logic          MEM_WRITE;
  logic [AW-1:0] MEM_ADDRESS;
  logic [DW-1:0] MEM_WRITEDATA;
  logic [DW-1:0] MEM_READDATA;
  logic          MEM_BUSYWAIT;

  always #5 CLK = ~CLK;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS),
    .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE),
    .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  // memory: busy from strobe edge for 1+lat cycles, writes commit on completion
  logic [DW-1:0] mem_arr [256];
  bit            written [256];
  logic          m_started = 1'b0;
  int            m_rem = 0;
  int            lat = 2;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    logic [31:0] w;
    w = 32'hDEADBEEF + 32'(a) - 32'h40;
    return {4{w}};
  endfunction

  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) &
                        (~m_started | (m_rem != 0));
  assign MEM_READDATA = written[MEM_ADDRESS[7:0]] ?
                        mem_arr[MEM_ADDRESS[7:0]] : pat(MEM_ADDRESS);

  always @(posedge CLK) begin
    if (!(MEM_READ || MEM_WRITE)) begin
      m_started <= 1'b0;
    end else if (!m_started) begin
      m_started <= 1'b1;
      m_rem     <= lat;
    end else if (m_rem != 0) begin
      m_rem <= m_rem - 1;
    end else if (MEM_WRITE) begin
      mem_arr[MEM_ADDRESS[7:0]] <= MEM_WRITEDATA;
      written[MEM_ADDRESS[7:0]] <= 1'b1;
    end
  end

  // reference model: one in-flight transaction, a release slot, last winner
  int            own, rel, last, age;
  bit            isrd;
  logic          e_mrd, e_mwr;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_ird, e_drd;
  bit            prev_ibw, prev_dbw;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(input string name,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    own = 0; rel = 0; last = IS; age = 0; isrd = 0;
    e_mrd = 0; e_mwr = 0; e_addr = '0; e_wdata = '0;
    e_ird = '0; e_drd = '0;
  endtask

  task automatic model_edge();
    bit dq, iq, take_d;
    dq = D_READ || D_WRITE;
    iq = I_READ;
    if (RESET) begin
      model_reset();
    end else if (rel != 0) begin
      rel = 0;
    end else if (own != 0) begin
      if (age >= 1 && !MEM_BUSYWAIT) begin
        if (isrd && own == DS && D_READ) e_drd = MEM_READDATA;
        if (isrd && own == IS && I_READ) e_ird = MEM_READDATA;
        e_mrd = 0; e_mwr = 0;
        rel = own; own = 0;
      end else begin
        age++;
      end
    end else begin
`ifdef MEM_ARB_RR_EN
      take_d = dq && (!iq || last != DS);
`else
      take_d = dq;
`endif
      if (take_d) begin
        own = DS; last = DS; age = 0;
        isrd = D_READ && !D_WRITE;
        e_mrd = isrd; e_mwr = D_WRITE;
        e_addr = D_ADDRESS; e_wdata = D_WRITEDATA;
      end else if (iq) begin
        own = IS; last = IS; age = 0; isrd = 1;
        e_mrd = 1; e_mwr = 0; e_addr = I_ADDRESS;
      end
    end
  endtask

  // called at a falling edge after inputs are driven
  task automatic step();
    logic e_ibw, e_dbw;
    #1;
    if (RESET) model_reset();
    e_ibw = !RESET && I_READ && rel != IS;
    e_dbw = !RESET && (D_READ || D_WRITE) && rel != DS;
    chk("i_busy", DW'(I_BUSYWAIT), DW'(e_ibw));
    chk("d_busy", DW'(D_BUSYWAIT), DW'(e_dbw));
    chk("mem_read", DW'(MEM_READ), DW'(e_mrd));
    chk("mem_write", DW'(MEM_WRITE), DW'(e_mwr));
    chk("mem_addr", DW'(MEM_ADDRESS), DW'(e_addr));
    chk("mem_wdata", MEM_WRITEDATA, e_wdata);
    chk("i_rdata", I_READDATA, e_ird);
    chk("d_rdata", D_READDATA, e_drd);
    prev_ibw = e_ibw;
    prev_dbw = e_dbw;
    model_edge();
    @(negedge CLK);
  endtask

  task automatic drain(input int n);
    I_READ = 0; D_READ = 0; D_WRITE = 0;
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    logic [DW-1:0] wd;
    logic [DW-1:0] beef;
    int            ord[$];
    int            exp_ord[4];
    bit            pv;
    int            op;
    beef = {4{32'hDEADBEEF}};
    model_reset();
    #2 RESET = 1;
    @(negedge CLK);
    step();
    chk("rst_mem_read", DW'(MEM_READ), '0);
    chk("rst_mem_addr", DW'(MEM_ADDRESS), '0);
    chk("rst_i_rdata", I_READDATA, '0);
    RESET = 0;
    step();

    // single I read of 0x40
    lat = 2;
    I_READ = 1; I_ADDRESS = 28'h40;
    step();
    chk("t1_mem_read", DW'(MEM_READ), DW'(1));
    chk("t1_mem_addr", DW'(MEM_ADDRESS), DW'(28'h40));
    chk("t1_i_busy", DW'(I_BUSYWAIT), DW'(1));
    for (int k = 0; k < 30 && I_BUSYWAIT; k++) step();
    chk("t1_i_busy_end", DW'(I_BUSYWAIT), '0);
    chk("t1_i_rdata", I_READDATA, beef);
    drain(2);

    // simultaneous I read and D write
    lat = 1;
    I_READ = 1; I_ADDRESS = 28'h30;
    D_WRITE = 1; D_ADDRESS = 28'h10;
    D_WRITEDATA = {16{8'hA5}};
    step();
    chk("t2_mem_write", DW'(MEM_WRITE), DW'(1));
    chk("t2_mem_addr", DW'(MEM_ADDRESS), DW'(28'h10));
    for (int k = 0; k < 30 && D_BUSYWAIT; k++) step();
    chk("t2_d_busy_end", DW'(D_BUSYWAIT), '0);
    chk("t2_i_still_busy", DW'(I_BUSYWAIT), DW'(1));
    D_WRITE = 0;
    for (int k = 0; k < 10 && !MEM_READ; k++) step();
    chk("t2_i_grant", DW'(MEM_READ), DW'(1));
    chk("t2_i_addr", DW'(MEM_ADDRESS), DW'(28'h30));
    for (int k = 0; k < 30 && I_BUSYWAIT; k++) step();
    chk("t2_i_busy_end", DW'(I_BUSYWAIT), '0);
    drain(2);

    // both continuously pending: grant order
`ifdef MEM_ARB_RR_EN
    exp_ord = '{DS, IS, DS, IS};
`else
    exp_ord = '{DS, DS, DS, DS};
`endif
    I_READ = 1; I_ADDRESS = 28'h31;
    D_WRITE = 1; D_ADDRESS = 28'h21;
    D_WRITEDATA = {4{32'h0BAD_F00D}};
    for (int k = 0; k < 80 && ord.size() < 4; k++) begin
      pv = MEM_READ || MEM_WRITE;
      step();
      if (!pv && (MEM_READ || MEM_WRITE))
        ord.push_back(MEM_ADDRESS == 28'h21 ? DS : IS);
    end
    chk("t3_grants", DW'(ord.size()), DW'(4));
    for (int k = 0; k < 4 && k < ord.size(); k++)
      chk($sformatf("t3_grant%0d", k), DW'(ord[k]), DW'(exp_ord[k]));
    drain(12);

    // reset in the middle of a busy D read
    lat = 6;
    D_READ = 1; D_ADDRESS = 28'h5;
    step();
    step();
    RESET = 1;
    step();
    chk("t4_mem_read", DW'(MEM_READ), '0);
    chk("t4_mem_write", DW'(MEM_WRITE), '0);
    chk("t4_d_busy", DW'(D_BUSYWAIT), '0);
    chk("t4_i_busy", DW'(I_BUSYWAIT), '0);
    chk("t4_d_rdata", D_READDATA, '0);
    RESET = 0;
    drain(3);

    // D read dropped after grant
    lat = 2;
    D_READ = 1; D_ADDRESS = 28'h7;
    step();
    D_READ = 0;
    step();
    for (int k = 0; k < 20 && MEM_READ; k++) step();
    chk("t5_done", DW'(MEM_READ), '0);
    chk("t5_d_rdata", D_READDATA, '0);
    drain(2);

    // read+write together behaves as write
    wd = {$urandom, $urandom, $urandom, $urandom};
    D_READ = 1; D_WRITE = 1; D_ADDRESS = 28'h9;
    D_WRITEDATA = wd;
    step();
    chk("t6_mem_write", DW'(MEM_WRITE), DW'(1));
    chk("t6_mem_read", DW'(MEM_READ), '0);
    chk("t6_wdata", MEM_WRITEDATA, wd);
    for (int k = 0; k < 30 && D_BUSYWAIT; k++) step();
    chk("t6_d_busy_end", DW'(D_BUSYWAIT), '0);
    chk("t6_d_rdata", D_READDATA, '0);
    drain(2);
    D_READ = 1; D_ADDRESS = 28'h9;
    step();
    for (int k = 0; k < 30 && D_BUSYWAIT; k++) step();
    chk("t6_readback", D_READDATA, wd);
    drain(2);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      lat = $urandom_range(0, 3);
      if (RESET) RESET = 0;
      else if ($urandom_range(0, 499) == 0) RESET = 1;
      if (I_READ && prev_ibw) begin
        if ($urandom_range(0, 99) < 3) I_READ = 0;
        if ($urandom_range(0, 9) == 0)
          I_ADDRESS = AW'($urandom_range(0, 15));
      end else begin
        I_READ = $urandom_range(0, 99) < 40;
        I_ADDRESS = AW'($urandom_range(0, 15));
      end
      if ((D_READ || D_WRITE) && prev_dbw) begin
        if ($urandom_range(0, 99) < 3) begin
          D_READ = 0; D_WRITE = 0;
        end
        if ($urandom_range(0, 9) == 0) begin
          D_ADDRESS = AW'($urandom_range(0, 15));
          D_WRITEDATA = {$urandom, $urandom, $urandom, $urandom};
        end
      end else begin
        op = $urandom_range(0, 7);
        D_READ = (op == 1) || (op == 3) || (op == 4);
        D_WRITE = (op == 2) || (op == 3) || (op == 5);
        D_ADDRESS = AW'($urandom_range(0, 15));
        D_WRITEDATA = {$urandom, $urandom, $urandom, $urandom};
      end
      step();
    end
    RESET = 0;
    drain(4);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
